// File: rtl/rom_token_reader.sv
// Walks a combinational expression ROM from address 0 and folds decimal digit runs into operands.
// Emits operand/operator tokens over valid/ready and stops at the '#' terminator.
module rom_token_reader #(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int DW    = 8,
  parameter int VW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_index,
  input  logic [DW-1:0] rom_data,
  output logic          tok_valid,
  input  logic          tok_ready,
  output logic          tok_is_op,
  output logic [VW-1:0] tok_value,
  output logic [1:0]    tok_op,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_EMIT_NUM, S_EMIT_OP, S_EMIT_LAST, S_DONE, S_ERR
  } state_t;

  localparam logic [AW-1:0] END_IDX = AW'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] rom_index_q, rom_index_d;
  logic [VW-1:0] acc_q, acc_d;
  logic          have_num_q, have_num_d;
  logic [1:0]    op_q, op_d;

  logic          is_digit, is_oper, is_end;
  logic [DW-1:0] op_off;
  logic [VW+3:0] acc_next;

  assign is_digit = rom_data < DW'(10);
  assign is_end   = rom_data == DW'(10);
  assign is_oper  = (rom_data >= DW'(11)) && (rom_data <= DW'(14));
  assign op_off   = rom_data - DW'(11);
  // Widened so an overflowing accumulation is visible instead of wrapping.
  assign acc_next = (VW+4)'(acc_q) * (VW+4)'(10) + (VW+4)'(rom_data[3:0]);

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    rom_index_d = rom_index_q;
    acc_d       = acc_q;
    have_num_d  = have_num_q;
    op_d        = op_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_SCAN;
          rom_index_d = '0;
          acc_d       = '0;
          have_num_d  = 1'b0;
        end
      end
      S_SCAN: begin
        if (rom_index_q == END_IDX) begin
          state_d = S_ERR;
        end else if (is_digit) begin
          if (acc_next[VW+3:VW] != 4'd0) begin
            state_d = S_ERR;
          end else begin
            acc_d       = acc_next[VW-1:0];
            have_num_d  = 1'b1;
            rom_index_d = rom_index_q + AW'(1);
          end
        end else if (is_oper) begin
          if (have_num_q) begin
            op_d        = op_off[1:0];
            state_d     = S_EMIT_NUM;
            rom_index_d = rom_index_q + AW'(1);
          end else begin
            state_d = S_ERR;
          end
        end else if (is_end) begin
          state_d = have_num_q ? S_EMIT_LAST : S_ERR;
        end else begin
          state_d = S_ERR;
        end
      end
      S_EMIT_NUM: begin
        if (tok_ready) begin
          state_d    = S_EMIT_OP;
          acc_d      = '0;
          have_num_d = 1'b0;
        end
      end
      S_EMIT_OP: begin
        if (tok_ready) state_d = S_SCAN;
      end
      S_EMIT_LAST: begin
        if (tok_ready) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_index_q <= '0;
      acc_q       <= '0;
      have_num_q  <= 1'b0;
      op_q        <= 2'd0;
    end else begin
      state_q     <= state_d;
      rom_index_q <= rom_index_d;
      acc_q       <= acc_d;
      have_num_q  <= have_num_d;
      op_q        <= op_d;
    end
  end

  assign rom_index = rom_index_q;
  assign tok_valid = (state_q == S_EMIT_NUM) || (state_q == S_EMIT_OP) || (state_q == S_EMIT_LAST);
  assign tok_is_op = state_q == S_EMIT_OP;
  assign tok_value = ((state_q == S_EMIT_NUM) || (state_q == S_EMIT_LAST)) ? acc_q : '0;
  assign tok_op    = (state_q == S_EMIT_OP) ? op_q : 2'd0;
  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done      = state_q == S_DONE;
  assign error     = state_q == S_ERR;

endmodule

// File: tb/tb_rom_token_reader.sv
// Directed bench for rom_token_reader: a behavioural ROM array feeds the reader and each
// token, stall, error index and reset value is compared against hand-computed constants.
module tb_rom_token_reader;

  logic       clk = 1'b0;
  logic       rst, start, tok_ready;
  logic [6:0] rom_index;
  logic [7:0] rom_data;
  logic       tok_valid, tok_is_op, busy, done, error;
  logic [15:0] tok_value;
  logic [1:0] tok_op;

  logic [7:0] rom [0:127];
  logic       ready_base;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_index];

  rom_token_reader dut (
    .clk(clk), .rst(rst), .start(start), .rom_index(rom_index), .rom_data(rom_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_value(tok_value), .tok_op(tok_op), .busy(busy), .done(done), .error(error)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load(input int n, input int c0, input int c1, input int c2,
                      input int c3, input int c4, input int c5);
    int c [6];
    c = '{c0, c1, c2, c3, c4, c5};
    for (int i = 0; i < 128; i++) rom[i] = 8'd15;
    for (int i = 0; i < n; i++) rom[i] = c[i][7:0];
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for a token, checks it, holds it for `hold` stalled cycles, then accepts it.
  task automatic expect_token(input string tag, input logic is_op, input int value,
                              input int op, input int hold);
    logic [6:0] idx;
    for (int i = 0; i < 200 && !tok_valid; i++) tick();
    check({tag, "_valid"}, tok_valid, 1);
    check({tag, "_is_op"}, tok_is_op, is_op);
    check({tag, "_value"}, tok_value, value);
    check({tag, "_op"}, tok_op, op);
    idx = rom_index;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, tok_valid, 1);
      check({tag, "_hold_tok"}, {tok_is_op, tok_op, tok_value}, {is_op, op[1:0], value[15:0]});
      check({tag, "_hold_index"}, rom_index, idx);
    end
    tok_ready = 1'b1;
    tick();
    tok_ready = ready_base;
  endtask

  // Runs (bounded) until done or error, counting cycles in which a token was presented.
  task automatic wait_end(output int toks);
    toks = 0;
    for (int i = 0; i < 300 && !(done || error); i++) begin
      if (tok_valid) toks++;
      tick();
    end
    check("end_reached", done | error, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {tok_valid, tok_is_op, tok_op, busy, done, error}, 0);
    check({tag, "_index"}, rom_index, 0);
    check({tag, "_value"}, tok_value, 0);
  endtask

  initial begin
    int toks;
    rst = 1'b1;
    start = 1'b0;
    ready_base = 1'b1;
    tok_ready = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // 55 + 2 with the evaluator always ready
    load(5, 5, 5, 11, 2, 10, 0);
    do_start();
    check("t1_busy", busy, 1);
    expect_token("t1_num55", 0, 55, 0, 0);
    expect_token("t1_plus", 1, 0, 0, 0);
    expect_token("t1_num2", 0, 2, 0, 0);
    wait_end(toks);
    check("t1_done", {done, error, busy}, 3'b100);

    // Same ROM, three stalled cycles at every token
    ready_base = 1'b0;
    tok_ready = 1'b0;
    do_start();
    check("t2_restart_index", rom_index, 0);
    expect_token("t2_num55", 0, 55, 0, 3);
    expect_token("t2_plus", 1, 0, 0, 3);
    expect_token("t2_num2", 0, 2, 0, 3);
    ready_base = 1'b1;
    tok_ready = 1'b1;
    wait_end(toks);
    check("t2_done", {done, error}, 2'b10);

    // Largest operand, then one past it
    load(6, 6, 5, 5, 3, 5, 10);
    do_start();
    expect_token("t3_max", 0, 65535, 0, 0);
    wait_end(toks);
    check("t3_max_done", {done, error}, 2'b10);
    load(6, 6, 5, 5, 3, 6, 10);
    do_start();
    wait_end(toks);
    check("t3_ovf_error", {done, error}, 2'b01);
    check("t3_ovf_index", rom_index, 4);
    check("t3_ovf_tokens", toks, 0);

    // Illegal code and leading operator
    load(4, 5, 20, 1, 10, 0, 0);
    do_start();
    wait_end(toks);
    check("t4_illegal_error", error, 1);
    check("t4_illegal_index", rom_index, 1);
    check("t4_illegal_tokens", toks, 0);
    load(3, 11, 3, 10, 0, 0, 0);
    do_start();
    wait_end(toks);
    check("t4_lead_op_error", error, 1);
    check("t4_lead_op_index", rom_index, 0);

    // Zeros fill the whole ROM depth with no terminator
    load(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) rom[i] = 8'd0;
    do_start();
    wait_end(toks);
    check("t5_no_end_error", error, 1);
    check("t5_no_end_index", rom_index, 100);

    // Reset while an operator token is stalled
    load(4, 5, 12, 2, 10, 0, 0);
    ready_base = 1'b0;
    tok_ready = 1'b0;
    do_start();
    expect_token("t6_num5", 0, 5, 0, 0);
    tick();
    check("t6_op_stalled", {tok_valid, tok_is_op, tok_op}, 4'b1101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t6_after_rst");
    ready_base = 1'b1;
    tok_ready = 1'b1;
    do_start();
    check("t6_rescan_index", rom_index, 0);
    expect_token("t6_num5_again", 0, 5, 0, 0);
    expect_token("t6_minus", 1, 0, 1, 0);
    expect_token("t6_num2", 0, 2, 0, 0);
    wait_end(toks);
    check("t6_done", {done, error}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
